// File: rtl/window_reader_if.sv
// ---------------------------------------------------------------------------
// window_reader_if
// Purpose : streaming handshake bundle between the window reader and its
//           consumer (FIR/LMS datapath, debug dump path).
// Signals : sample - signed streamed sample
//           index  - position of sample within the stream (0..2**IDX_W-1)
//           valid  - sample/index/last carry a beat
//           ready  - consumer accepts the beat when valid && ready
//           last   - marks the final beat of a stream
// Modports: master (reader side), slave (consumer side)
// ---------------------------------------------------------------------------
interface window_reader_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 6
);
    logic signed [WIDTH-1:0] sample;
    logic [IDX_W-1:0]        index;
    logic                    valid;
    logic                    ready;
    logic                    last;

    modport master (
        output sample,
        output index,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  sample,
        input  index,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/window_reader.sv
// ---------------------------------------------------------------------------
// window_reader
// Purpose : on a start request, snapshots the circular sample window, its
//           write offset and the running norm, then streams the snapshotted
//           samples out in chronological order (or reversed) over a
//           valid/ready handshake. The live window may keep changing while
//           the stream is in progress.
// Ports   : clk_in     - system clock
//           rst_n_in   - asynchronous active-low reset
//           sample_in  - live window array, SAMPLES_SIZE entries of WIDTH bits
//           offset_in  - sampler write offset (index of the oldest entry)
//           norm_in    - live signed running sum of squares
//           start_in   - snapshot-and-stream request (accepted in IDLE only)
//           busy_out   - high from the snapshot until the return to IDLE
//           norm_out   - snapshotted norm, held until the next snapshot
//           done_out   - one-cycle pulse after the final handshake
//           stream     - sample/index/valid/ready/last handshake (master)
// ---------------------------------------------------------------------------
module window_reader #(
    parameter int SAMPLES_SIZE = 64,
    parameter int WIDTH        = 16,
    parameter bit NEWEST_FIRST = 1'b0
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic [SAMPLES_SIZE-1:0][WIDTH-1:0]     sample_in,
    input  logic [$clog2(SAMPLES_SIZE)-1:0]        offset_in,
    input  logic signed [31:0]                     norm_in,
    input  logic                                   start_in,
    output logic                                   busy_out,
    output logic signed [31:0]                     norm_out,
    output logic                                   done_out,
    window_reader_if.master                        stream
);
    localparam int IDX_W = $clog2(SAMPLES_SIZE);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(SAMPLES_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]                         rst_sync;
    logic                               rst_n;
    logic [SAMPLES_SIZE-1:0][WIDTH-1:0] snap;
    logic [IDX_W-1:0]                   base;
    logic [IDX_W-1:0]                   index_r;
    logic [WIDTH-1:0]                   sample_r;
    logic                               valid_r;
    logic                               last_r;
    logic                               load;
    logic                               advance;
    logic                               finish;
    logic [IDX_W-1:0]                   next_k;
    logic [IDX_W-1:0]                   first_addr;
    logic [IDX_W-1:0]                   next_addr;

    // Reset asserts asynchronously but releases two clocks later, so no flop
    // sees the deassertion close to a clock edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // The first beat is read straight from the live array on the snapshot
    // edge, because the snapshot register is not loaded yet at that point.
    // Later beats come from the snapshot. Index arithmetic is IDX_W wide, so
    // it wraps around the circular window for free.
    assign next_k     = index_r + ONE;
    assign first_addr = NEWEST_FIRST ? (offset_in - ONE) : offset_in;
    assign next_addr  = NEWEST_FIRST ? (base - ONE - next_k) : (base + next_k);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. Start requests outside IDLE are simply
    // dropped; nothing is queued.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    load       = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                busy_out = 1'b1;
                if (valid_r && stream.ready) begin
                    if (index_r == LAST_K) begin
                        finish     = 1'b1;
                        next_state = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                busy_out   = 1'b1;
                done_out   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Snapshot and output registers. A stalled beat holds every output
    // because none of the branches fires without a handshake.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            base     <= '0;
            norm_out <= '0;
            sample_r <= '0;
            index_r  <= '0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
        end else if (load) begin
            snap     <= sample_in;
            base     <= offset_in;
            norm_out <= norm_in;
            sample_r <= sample_in[first_addr];
            index_r  <= '0;
            valid_r  <= 1'b1;
            last_r   <= 1'b0;
        end else if (advance) begin
            sample_r <= snap[next_addr];
            index_r  <= next_k;
            last_r   <= (next_k == LAST_K);
        end else if (finish) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end
    end

    assign stream.sample = sample_r;
    assign stream.index  = index_r;
    assign stream.valid  = valid_r;
    assign stream.last   = last_r;
endmodule
